// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if -- bus bundle between the fetch unit and its environment.
//
// Signals
//   imem_req / imem_addr        fetch request pulse and word-aligned address
//   imem_rvalid / imem_rdata    instruction memory response (one per request)
//   redirect_valid / redirect_pc  restart fetch at a new address
//   out_valid / out_ready       decoded-instruction handshake
//   opcode .. imm, out_pc       decoded fields of the buffer head
//
// Handshake semantics: a transfer on the decoded-instruction port happens on a
// rising clock edge where out_valid and out_ready are both 1. While out_valid=1
// and out_ready=0 the head fields hold steady. out_valid never waits on
// out_ready. The imem port has no ready: imem_req is a single-cycle pulse and
// memory answers with exactly one imem_rvalid cycle, at least one cycle later.
//
// Modports
//   master  the fetch unit
//   slave   memory, branch unit and decoder side
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  regWriteNum;
    logic [4:0]  regNum0;
    logic [4:0]  regNum1;
    logic [31:0] imm;
    logic [31:0] out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output opcode, func3, func7, regWriteNum, regNum0, regNum1, imm, out_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  opcode, func3, func7, regWriteNum, regNum0, regNum1, imm, out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch with a small decoded-instruction buffer.
//
// Issues one fetch at a time to instruction memory, stores responses together
// with their fetch address in a FIFO, and presents the head entry split into
// RISC-V fields plus its sign-extended immediate. A redirect flushes the FIFO
// and restarts fetch; a response still in flight at that moment is dropped.
//
// Parameters
//   RESET_PC   address of the first fetch after reset
//   BUF_DEPTH  FIFO entries, 2 or 4
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   bus       fetch_unit_if.master (imem, redirect and decoded output)
//   dbgState  current FSM state (0 IDLE, 1 WAIT, 2 DRAIN)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus,
    output logic [1:0]   dbgState
);
    // BUF_DEPTH is a power of two, so pointers wrap naturally.
    localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } stateT;

    stateT            state;
    logic [31:0]      fetchPc;
    logic [31:0]      reqAddr;
    logic [31:0]      bufPc    [BUF_DEPTH];
    logic [31:0]      bufInstr [BUF_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] committed;
    logic             waitKept;
    logic             respDone;
    logic             issue;
    logic             push;
    logic             pop;
    logic             outValid;
    logic [31:0]      headInstr;
    logic [31:0]      headPc;
    logic [31:0]      immVal;

    assign outValid = (count != '0);
    assign waitKept = (state == WAIT);
    assign respDone = bus.imem_rvalid && (state != IDLE);

    // Slots already spoken for: buffered entries plus the kept request in
    // flight. The in-flight one still counts in the cycle its response lands,
    // which is what keeps back-to-back issue from overfilling the FIFO.
    assign committed = count + CNT_W'(waitKept);

    // Gated by reset so no request appears while reset is held.
    assign issue = reset && !bus.redirect_valid && (committed < DEPTH_C)
                   && ((state == IDLE) || respDone);

    assign push = bus.imem_rvalid && waitKept && !bus.redirect_valid;
    assign pop  = outValid && bus.out_ready && !bus.redirect_valid;

    // Control state. A redirect wins over every other event in its cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqAddr <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (bus.redirect_valid) begin
            fetchPc <= {bus.redirect_pc[31:2], 2'b00};
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            // A request still in flight must be drained; if its response
            // arrives right now it is simply dropped and nothing is left over.
            if (state != IDLE) begin
                state <= bus.imem_rvalid ? IDLE : DRAIN;
            end
        end else begin
            if (issue) begin
                reqAddr <= fetchPc;
                fetchPc <= fetchPc + 32'd4;
                state   <= WAIT;
            end else if (respDone) begin
                state   <= IDLE;
            end

            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload; validity is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            bufPc[wrPtr]    <= reqAddr;
            bufInstr[wrPtr] <= bus.imem_rdata;
        end
    end

    // An empty buffer presents an all-zero head, so every field reads 0.
    assign headInstr = outValid ? bufInstr[rdPtr] : 32'd0;
    assign headPc    = outValid ? bufPc[rdPtr]    : 32'd0;

    always_comb begin
        immVal = 32'd0;
        case (headInstr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                immVal = {{20{headInstr[31]}}, headInstr[31:20]};
            7'b0100011:
                immVal = {{20{headInstr[31]}}, headInstr[31:25], headInstr[11:7]};
            7'b1100011:
                immVal = {{19{headInstr[31]}}, headInstr[31], headInstr[7],
                          headInstr[30:25], headInstr[11:8], 1'b0};
            7'b1101111:
                immVal = {{11{headInstr[31]}}, headInstr[31], headInstr[19:12],
                          headInstr[20], headInstr[30:21], 1'b0};
            7'b0110111, 7'b0010111:
                immVal = {headInstr[31:12], 12'd0};
            default:
                immVal = 32'd0;
        endcase
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetchPc;
    assign bus.out_valid   = outValid;
    assign bus.opcode      = headInstr[6:0];
    assign bus.func3       = headInstr[14:12];
    assign bus.func7       = headInstr[31:25];
    assign bus.regWriteNum = headInstr[11:7];
    assign bus.regNum0     = headInstr[19:15];
    assign bus.regNum1     = headInstr[24:20];
    assign bus.imm         = immVal;
    assign bus.out_pc      = headPc;
    assign dbgState        = state;
endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- randomized bench for fetch_unit with a queue scoreboard.
//
// The memory responder pushes {cycle, address, word} for every response that
// should survive (no redirect between request and response). The monitor,
// on the falling edge, compares the head against that queue, checks out_valid,
// and checks every cycle whether a fetch must be issued and at which address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbgState;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .dbgState(dbgState)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // ---------------- shared model state ----------------
    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned popCount = 0;

    logic [95:0] exp_q[$];         // {push cycle, pc, instr}
    logic        pendValid  = 1'b0;
    logic        pendKilled = 1'b0;
    logic [31:0] pendAddr   = 32'd0;
    int          pendWait   = 0;
    logic [31:0] modelPc    = RESET_PC;

    int latMin   = 1;
    int latMax   = 1;
    int readyPct = 100;
    int redirPct = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory content: fixed words at 0/4/8, hashed elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  op;
        if (a == 32'd0) return 32'h0050_0093;
        if (a == 32'd4) return 32'hFE00_0EE3;
        if (a == 32'd8) return 32'h8000_00EF;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        case (h[3:0])
            4'd0:    op = 7'h13;
            4'd1:    op = 7'h03;
            4'd2:    op = 7'h67;
            4'd3:    op = 7'h23;
            4'd4:    op = 7'h63;
            4'd5:    op = 7'h6F;
            4'd6:    op = 7'h37;
            4'd7:    op = 7'h17;
            4'd8:    op = 7'h33;
            default: op = h[10:4];
        endcase
        return {h[31:7], op};
    endfunction

    // Sign-extend the low w bits of v using plain arithmetic.
    function automatic logic [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = 32'd1 << (w - 1);
        return ((v & ((top << 1) - 32'd1)) ^ top) - top;
    endfunction

    function automatic logic [31:0] refImm(input logic [31:0] i);
        logic [31:0] f;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return sext(i >> 20, 12);
            7'h23: begin
                f = ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
                return sext(f, 12);
            end
            7'h63: begin
                f = (((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11)
                  | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
                return sext(f, 13);
            end
            7'h6F: begin
                f = (((i >> 31) & 1) << 20) | (((i >> 12) & 32'hFF) << 12)
                  | (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1);
                return sext(f, 21);
            end
            7'h37, 7'h17: return i & 32'hFFFF_F000;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic driveCycle();
        @(posedge clk);
        #1;
        bus.redirect_valid = ($urandom_range(0, 99) < redirPct);
        if (bus.redirect_valid) begin
            case ($urandom_range(0, 3))
                0:       bus.redirect_pc = 32'h0000_0103;
                1:       bus.redirect_pc = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
                2:       bus.redirect_pc = 32'($urandom_range(0, 1023));
                default: bus.redirect_pc = $urandom;
            endcase
        end
        bus.out_ready   = ($urandom_range(0, 99) < readyPct);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (pendValid) begin
            if (pendWait <= 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memWord(pendAddr);
                if (!pendKilled && !bus.redirect_valid) begin
                    exp_q.push_back({32'(cycleCnt), pendAddr, memWord(pendAddr)});
                end
            end else begin
                pendWait--;
            end
        end
    endtask

    task automatic applyReset();
        reset = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.out_ready      = 1'b0;
        pendValid  = 1'b0;
        pendKilled = 1'b0;
        exp_q.delete();
        modelPc = RESET_PC;
        #1;
        check("rst imem_req",   32'(bus.imem_req), 32'd0);
        check("rst imem_addr",  bus.imem_addr, RESET_PC);
        check("rst out_valid",  32'(bus.out_valid), 32'd0);
        check("rst opcode",     32'(bus.opcode), 32'd0);
        check("rst func3",      32'(bus.func3), 32'd0);
        check("rst func7",      32'(bus.func7), 32'd0);
        check("rst rd",         32'(bus.regWriteNum), 32'd0);
        check("rst rs1",        32'(bus.regNum0), 32'd0);
        check("rst rs2",        32'(bus.regNum1), 32'd0);
        check("rst imm",        bus.imm, 32'd0);
        check("rst out_pc",     bus.out_pc, 32'd0);
        $display("info: state code during reset %0d", dbgState);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          bufItems;
    logic        expValid;
    logic        keptPend;
    logic        expReq;
    logic [95:0] head;
    logic [31:0] hPc;
    logic [31:0] hIns;

    always @(negedge clk) begin
        if (reset) begin
            bufItems = 0;
            foreach (exp_q[k]) begin
                if (exp_q[k][95:64] < 32'(cycleCnt)) bufItems++;
            end
            expValid = (bufItems > 0);
            check("out_valid", 32'(bus.out_valid), 32'(expValid));

            if (bus.out_valid && expValid) begin
                head = exp_q[0];
                hPc  = head[63:32];
                hIns = head[31:0];
                check("out_pc",      bus.out_pc, hPc);
                check("opcode",      32'(bus.opcode), 32'(hIns[6:0]));
                check("func3",       32'(bus.func3), 32'(hIns[14:12]));
                check("func7",       32'(bus.func7), 32'(hIns[31:25]));
                check("regWriteNum", 32'(bus.regWriteNum), 32'(hIns[11:7]));
                check("regNum0",     32'(bus.regNum0), 32'(hIns[19:15]));
                check("regNum1",     32'(bus.regNum1), 32'(hIns[24:20]));
                check("imm",         bus.imm, refImm(hIns));
                if (hPc == 32'd0) begin
                    check("addi opcode", 32'(bus.opcode), 32'h13);
                    check("addi rd",     32'(bus.regWriteNum), 32'd1);
                    check("addi imm",    bus.imm, 32'd5);
                end
                if (hPc == 32'd4) begin
                    check("beq opcode", 32'(bus.opcode), 32'h63);
                    check("beq imm",    bus.imm, 32'hFFFF_FFFC);
                end
                if (hPc == 32'd8) begin
                    check("jal opcode", 32'(bus.opcode), 32'h6F);
                    check("jal imm",    bus.imm, 32'hFFF0_0000);
                end
            end

            // A fetch is due when nothing is outstanding (or it completes now),
            // no redirect is present, and buffered plus kept-in-flight work
            // leaves room in the buffer.
            keptPend = pendValid && !pendKilled;
            expReq = !bus.redirect_valid && (!pendValid || bus.imem_rvalid)
                     && ((bufItems + int'(keptPend)) < BUF_DEPTH);
            check("imem_req", 32'(bus.imem_req), 32'(expReq));
            if (bus.imem_req) begin
                check("imem_addr", bus.imem_addr, modelPc);
            end

            if (bus.out_valid && bus.out_ready && !bus.redirect_valid && expValid) begin
                void'(exp_q.pop_front());
                popCount++;
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                modelPc = {bus.redirect_pc[31:2], 2'b00};
                if (pendValid) pendKilled = 1'b1;
            end
            if (bus.imem_rvalid) begin
                pendValid = 1'b0;
            end
            if (bus.imem_req) begin
                pendValid  = 1'b1;
                pendKilled = 1'b0;
                pendAddr   = bus.imem_addr;
                pendWait   = $urandom_range(latMin, latMax);
                modelPc    = modelPc + 32'd4;
            end

            keptPend = pendValid && !pendKilled;
            check("occupancy bound", 32'((exp_q.size() + int'(keptPend)) <= BUF_DEPTH), 32'd1);
        end
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        int tries;
        applyReset();

        // Latency 1, decoder always ready: stream from 0 with back-to-back issue.
        latMin = 1; latMax = 1; readyPct = 100; redirPct = 0;
        repeat (30) driveCycle();

        // Decoder stalls: only BUF_DEPTH fetches may be in the buffer.
        readyPct = 0;
        repeat (12) driveCycle();
        readyPct = 100;
        repeat (10) driveCycle();

        // Mixed latency, back-pressure and redirects.
        latMin = 1; latMax = 3; readyPct = 60; redirPct = 10;
        repeat (1500) driveCycle();

        // Heavier redirect traffic with longer latency (drain paths).
        latMin = 2; latMax = 3; readyPct = 50; redirPct = 25;
        repeat (500) driveCycle();

        // Reset asserted while a request is outstanding.
        latMin = 4; latMax = 4; readyPct = 30; redirPct = 0;
        tries = 0;
        while (!(pendValid && !pendKilled) && tries < 30) begin
            driveCycle();
            tries++;
        end
        check("reached WAIT before reset", 32'(pendValid && !pendKilled), 32'd1);
        #2;
        applyReset();

        latMin = 1; latMax = 3; readyPct = 70; redirPct = 8;
        repeat (300) driveCycle();

        check("enough instructions delivered", 32'(popCount > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  one-cycle pulse issuing a fetch at imem_addr.
REQ-006 imem_addr  output  32  word-aligned fetch address; valid when imem_req=1.
REQ-007 imem_rvalid  input  1  response strobe; one cycle per request, at least 1 cycle after imem_req.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
REQ-009 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc (taken branch, jal, jalr).
REQ-010 redirect_pc  input  32  new fetch address.
REQ-011 out_valid  output  1  buffer head holds a decoded instruction.
REQ-012 out_ready  input  1  decoder accepts the head; transfer when out_valid & out_ready.
REQ-013 opcode 7 / func3 3 / func7 7 / regWriteNum 5 / regNum0 5 / regNum1 5  output  instr[6:0], [14:12], [31:25], [11:7], [19:15], [24:20] of the head entry.
REQ-014 imm  output  32  sign-extended immediate of the head entry.
REQ-015 out_pc  output  32  address of the head entry.

Function
REQ-016 States: IDLE (no request outstanding), WAIT (one request outstanding, response kept), DRAIN (one request outstanding, response discarded).
REQ-017 At most one outstanding request; imem_req only in IDLE, or in WAIT/DRAIN in the cycle imem_rvalid arrives (back-to-back issue).
REQ-018 Issue condition: buffer occupancy plus outstanding-kept requests < BUF_DEPTH, and no redirect_valid this cycle.
REQ-019 On issue, imem_addr = fetch_pc; fetch_pc <= fetch_pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); state -> WAIT.
REQ-020 In WAIT on imem_rvalid: push {fetch address, imem_rdata} into the buffer; state -> WAIT if reissuing, else IDLE.
REQ-021 In DRAIN on imem_rvalid: discard the response; push nothing; state -> IDLE, or WAIT if reissuing.
REQ-022 Buffer is a FIFO; push and pop in the same cycle are both allowed when full; occupancy never exceeds BUF_DEPTH.
REQ-023 out_valid = buffer not empty; head fields are combinational from the head entry and stay stable while out_valid & !out_ready.
REQ-024 Decoder latency: a response captured at edge N is presented at out_* after edge N, with no additional cycle.
REQ-025 Immediate: I (0010011, 0000011, 1100111) = sext(i[31:20]); S (0100011) = sext({i[31:25],i[11:7]}); B (1100011) = sext({i[31],i[7],i[30:25],i[11:8],1'b0}); J (1101111) = sext({i[31],i[19:12],i[20],i[30:21],1'b0}); U (0110111, 0010111) = {i[31:12],12'b0}; any other opcode gives 0.
REQ-026 redirect_valid has priority over all same-cycle events: flush the buffer (same-cycle pop ignored, out_valid=0 next cycle); fetch_pc <= {redirect_pc[31:2],2'b00}; no imem_req that cycle.
REQ-027 Redirect while WAIT: state -> DRAIN. If imem_rvalid arrives in the same cycle, the response is discarded and the state goes to IDLE. A redirect in IDLE or DRAIN keeps the state unchanged.
REQ-028 The first issue after a redirect occurs in the cycle after the redirect, or in the cycle the DRAIN response arrives, whichever is later.
REQ-029 imem_rvalid in IDLE is a protocol error; it is ignored.

Reset
REQ-030 While reset=0: state=IDLE, fetch_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, out_valid=0, opcode/func3/func7/regWriteNum/regNum0/regNum1/imm=0, out_pc=0.
REQ-031 Reset asserted mid-request drops the outstanding request; any imem_rvalid in the first cycle after release is ignored.
REQ-032 First imem_req is in the first cycle after reset deasserts.

Verification
REQ-033 Reset release, imem latency 1, out_ready=1, rdata 32'h00500093 at 0 -> imem_req addr 0; next cycle out_valid=1, opcode=7'h13, regWriteNum=1, imm=5, out_pc=0; back-to-back requests at 4, 8.
REQ-034 out_ready=0, BUF_DEPTH=2 -> exactly 2 requests issued (0, 4); no third until a pop; raising out_ready pops 0 then 4, and issue of 8 resumes.
REQ-035 rdata 32'hFE000EE3 (beq x0,x0,-4) -> opcode=7'h63, imm=32'hFFFF_FFFC; rdata 32'h800000EF (jal) -> imm=32'hFFF0_0000.
REQ-036 Redirect to 32'h0000_0103 during WAIT with rvalid 2 cycles later -> that response discarded, out_valid stays 0, next imem_addr=32'h0000_0100.
REQ-037 Redirect, rvalid and out_valid&out_ready in the same cycle -> buffer empty next cycle, response dropped, state IDLE.
REQ-038 fetch_pc=32'hFFFF_FFFC issue -> next imem_addr=0; reset=0 asserted while WAIT -> all outputs at REQ-030 values immediately, without waiting for a clock edge.
